// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial unpacker: word counts, lane geometry
// and the FSM state encoding used by poly_unpack_bram.
package poly_pkg;

    localparam int POLY_WORDS_4X       = 64;
    localparam int POLY_WORDS_PACKED13 = 52;
    localparam int COEFF_W             = 13;
    localparam int LANE_W              = 16;

    // Four lanes per destination word
    localparam int LANES       = 4;
    localparam int PACKED_BITS = LANES * COEFF_W;   // 52 bits consumed per EMIT
    localparam int WORD_W      = LANES * LANE_W;    // 64-bit BRAM word
    localparam int BUF_W       = 128;               // holds up to 115 live bits

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAP  = 3'd3,
        ST_EMIT = 3'd4,
        ST_DONE = 3'd5
    } unpack_state_t;

endpackage

// File: rtl/coeff_lane_expand.sv
// Combinational expansion of four packed 13-bit coefficients into four
// 16-bit lanes. Build macro POLY_UNPACK_SIGNEXT_EN selects sign extension
// (bit 12 replicated into 15:13); without it the lanes are zero-extended.
module coeff_lane_expand
    import poly_pkg::*;
(
    input  logic [PACKED_BITS-1:0] i_bits,
    output logic [WORD_W-1:0]      o_lanes
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [COEFF_W-1:0] w_coeff;
        assign w_coeff = i_bits[g*COEFF_W +: COEFF_W];
`ifdef POLY_UNPACK_SIGNEXT_EN
        assign o_lanes[g*LANE_W +: LANE_W] = {{(LANE_W-COEFF_W){w_coeff[COEFF_W-1]}}, w_coeff};
`else
        assign o_lanes[g*LANE_W +: LANE_W] = {{(LANE_W-COEFF_W){1'b0}}, w_coeff};
`endif
    end

endmodule

// File: rtl/poly_unpack_bram.sv
// Rewrites a polynomial from the source BRAM into the destination BRAM as
// 64 words of four 16-bit coefficients. Packed 13-bit input (52 words) is
// streamed through a 128-bit bit buffer; 4x input (64 words) is copied.
// Lane extension of packed coefficients depends on POLY_UNPACK_SIGNEXT_EN
// (see coeff_lane_expand).
module poly_unpack_bram
    import poly_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              coeff4x,
    output logic [5:0]        src_addr,
    input  logic [WORD_W-1:0] src_data,
    output logic [5:0]        dst_addr,
    output logic [WORD_W-1:0] dst_data,
    output logic              dst_we,
    output logic              done
);

    localparam logic [BUF_W-1:0] WORD_MASK = {{(BUF_W-WORD_W){1'b0}}, {WORD_W{1'b1}}};
    localparam logic [6:0]       CNT_WORD  = 7'(WORD_W);
    localparam logic [6:0]       CNT_EMIT  = 7'(PACKED_BITS);
    localparam logic [6:0]       CNT_TWICE = 7'(2 * PACKED_BITS);
    localparam logic [5:0]       LAST_WR   = 6'(POLY_WORDS_4X - 1);

    unpack_state_t     r_state;
    unpack_state_t     w_next;
    logic              r_mode;        // 1 = 4x copy, 0 = packed 13-bit
    logic [5:0]        r_rd_cnt;
    logic [5:0]        r_wr_cnt;
    logic [BUF_W-1:0]  r_buf;
    logic [6:0]        r_cnt;         // number of valid bits in r_buf

    logic [BUF_W-1:0]  w_cap_buf;
    logic [6:0]        w_cap_cnt;
    logic [WORD_W-1:0] w_lanes;

    // Packed capture: overwrite 64 bits starting at the current fill level.
    // Bits above the fill level are always zero, but the mask keeps the
    // insert exact regardless.
    assign w_cap_buf = (r_buf & ~(WORD_MASK << r_cnt))
                     | ({{(BUF_W-WORD_W){1'b0}}, src_data} << r_cnt);
    assign w_cap_cnt = r_cnt + CNT_WORD;

    coeff_lane_expand u_expand (
        .i_bits  (r_buf[PACKED_BITS-1:0]),
        .o_lanes (w_lanes)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RD;
                end
            end
            ST_RD: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_CAP;
            end
            ST_CAP: begin
                if (r_mode) begin
                    w_next = ST_EMIT;
                end else if (w_cap_cnt >= CNT_EMIT) begin
                    w_next = ST_EMIT;
                end else begin
                    w_next = ST_RD;
                end
            end
            ST_EMIT: begin
                // Last word wins over a pending second emit
                if (r_wr_cnt == LAST_WR) begin
                    w_next = ST_DONE;
                end else if (!r_mode && (r_cnt >= CNT_TWICE)) begin
                    w_next = ST_EMIT;
                end else begin
                    w_next = ST_RD;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Counters, mode latch and bit buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_buf    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mode   <= coeff4x;
                    r_rd_cnt <= '0;
                    r_wr_cnt <= '0;
                    r_buf    <= '0;
                    r_cnt    <= '0;
                end
                ST_CAP: begin
                    r_rd_cnt <= r_rd_cnt + 6'd1;
                    if (r_mode) begin
                        r_buf[WORD_W-1:0] <= src_data;
                        r_cnt             <= CNT_WORD;
                    end else begin
                        r_buf <= w_cap_buf;
                        r_cnt <= w_cap_cnt;
                    end
                end
                ST_EMIT: begin
                    r_wr_cnt <= r_wr_cnt + 6'd1;
                    if (r_mode) begin
                        r_cnt <= '0;
                    end else begin
                        r_buf <= r_buf >> PACKED_BITS;
                        r_cnt <= r_cnt - CNT_EMIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign src_addr = r_rd_cnt;
    assign dst_addr = r_wr_cnt;
    assign dst_we   = (r_state == ST_EMIT);
    assign done     = (r_state == ST_DONE);
    assign dst_data = r_mode ? r_buf[WORD_W-1:0] : w_lanes;

endmodule

// File: tb/tb_poly_unpack_bram.sv
// Directed bench for poly_unpack_bram: packed ramp, packed all-ones
// (extension depends on POLY_UNPACK_SIGNEXT_EN), 4x copy, done handshake,
// and reset in the middle of a run.
module tb_poly_unpack_bram;

    logic        clk;
    logic        rst;
    logic        start;
    logic        coeff4x;
    logic [5:0]  src_addr;
    logic [63:0] src_data;
    logic [5:0]  dst_addr;
    logic [63:0] dst_data;
    logic        dst_we;
    logic        done;

    logic [63:0] src_mem [64];
    logic [63:0] dst_mem [64];
    logic [63:0] r_rd1;

    int n_vec;
    int n_err;

    poly_unpack_bram dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .coeff4x  (coeff4x),
        .src_addr (src_addr),
        .src_data (src_data),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_we   (dst_we),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-registered source BRAM: two edges from address to data
    always @(posedge clk) begin
        r_rd1    <= src_mem[src_addr];
        src_data <= r_rd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pack 256 copies of a 13-bit value pattern LSB-first into words 0..51
    task automatic load_packed(input bit ramp, input logic [12:0] val);
        logic [12:0] c;
        int p;
        for (int w = 0; w < 64; w++) src_mem[w] = '0;
        for (int k = 0; k < 256; k++) begin
            c = ramp ? 13'(k) : val;
            for (int b = 0; b < 13; b++) begin
                p = 13 * k + b;
                src_mem[p / 64][p % 64] = c[b];
            end
        end
    endtask

    task automatic load_4x();
        for (int w = 0; w < 64; w++) src_mem[w] = 64'hA5A5_0000_0000_0000 + 64'(w);
    endtask

    // kind 0: ramp lanes 4j+i; kind 1: all 0x1FFF extended; kind 2: copy of source
    task automatic check_dst(input int kind);
        logic [63:0] e;
        logic [15:0] ones;
`ifdef POLY_UNPACK_SIGNEXT_EN
        ones = 16'hFFFF;
`else
        ones = 16'h1FFF;
`endif
        for (int j = 0; j < 64; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (kind == 0) e[16*i +: 16] = 16'(4 * j + i);
                else           e[16*i +: 16] = ones;
            end
            if (kind == 2) e = 64'hA5A5_0000_0000_0000 + 64'(j);
            chk($sformatf("dst_word%0d_k%0d", j, kind), dst_mem[j], e);
        end
    endtask

    // Raise start with the given mode and follow the run until done
    task automatic run_conv(input bit mode, input int exp_done);
        int  cyc, first_we, done_cyc, n_we, run_len, n_runs, bad_runs, p;
        bit  prev_we;
        for (int w = 0; w < 64; w++) dst_mem[w] = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        coeff4x = mode;
        start   = 1'b1;
        cyc = 0; first_we = -1; done_cyc = -1; n_we = 0;
        run_len = 0; n_runs = 0; bad_runs = 0; prev_we = 1'b0;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("first_rd_addr", 64'(src_addr), 64'd0);
                chk("first_rd_we", 64'(dst_we), 64'd0);
            end
            if (cyc == 5) chk("second_rd_addr", 64'(src_addr), 64'd1);
            if (dst_we) begin
                dst_mem[dst_addr] = dst_data;
                n_we++;
                run_len++;
                if (first_we < 0) first_we = cyc;
            end else if (prev_we) begin
                // Packed emit bursts repeat 1,1,1,1,2,1,1,1,2,1,1,1,2
                p = n_runs % 13;
                if (!mode && run_len != ((p == 4 || p == 8 || p == 12) ? 2 : 1)) bad_runs++;
                if (mode && run_len != 1) bad_runs++;
                n_runs++;
                run_len = 0;
            end
            prev_we = dst_we;
            if (done) done_cyc = cyc;
        end
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("we_count", 64'(n_we), 64'd64);
        chk("first_we_cycle", 64'(first_we), 64'd4);
        chk("emit_runs", 64'(n_runs), mode ? 64'd64 : 64'd52);
        chk("emit_pattern", 64'(bad_runs), 64'd0);
    endtask

    task automatic hold_then_drop();
        repeat (3) @(negedge clk);
        chk("done_hold", 64'(done), 64'd1);
        chk("hold_we", 64'(dst_we), 64'd0);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", 64'(done), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_src_addr"}, 64'(src_addr), 64'd0);
        chk({tag, "_dst_addr"}, 64'(dst_addr), 64'd0);
        chk({tag, "_dst_data"}, dst_data, 64'd0);
        chk({tag, "_dst_we"}, 64'(dst_we), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n, cyc, extra;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        coeff4x = 1'b0;
        for (int w = 0; w < 64; w++) src_mem[w] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Packed ramp c[k] = k
        load_packed(1'b1, 13'd0);
        run_conv(1'b0, 221);
        check_dst(0);
        hold_then_drop();

        // 4x copy, coeff4x freshly sampled on restart
        load_4x();
        run_conv(1'b1, 257);
        check_dst(2);
        hold_then_drop();

        // Packed all-ones coefficients exercise the lane extension
        load_packed(1'b0, 13'h1FFF);
        run_conv(1'b0, 221);
        check_dst(1);
        hold_then_drop();

        // Reset after the tenth write, then a clean rerun
        load_packed(1'b1, 13'd0);
        @(negedge clk);
        coeff4x = 1'b0;
        start   = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dst_we) n++;
        end
        chk("pre_rst_writes", 64'(n), 64'd10);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (dst_we) extra++;
        end
        chk("post_rst_we", 64'(extra), 64'd0);
        run_conv(1'b0, 221);
        check_dst(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
